// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and address field helpers for the data cache.
package dcache_pkg;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 2;
  localparam int CNT_W    = 16;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FILL    = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  // Word address of the first word in the block holding a.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return {get_tag(a), get_index(a), {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped storage: data words, tags and valid bits, combinational read.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_word,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                fill_done,
  input  logic [TAG_W-1:0]    wr_tag
);

  localparam int BLOCKS = 1 << INDEX_W;
  localparam int WORDS  = 1 << OFFSET_W;

  logic [DATA_W-1:0] data_mem [BLOCKS][WORDS];
  logic [TAG_W-1:0]  tag_mem  [BLOCKS];
  logic [BLOCKS-1:0] valid;

  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid[index];
  assign rd_word  = data_mem[index][rd_offset];

  // Data and tag storage are not reset; validity alone decides a hit.
  always_ff @(posedge clk) begin
    if (word_we) data_mem[index][wr_offset] <= wr_data;
    if (fill_done) tag_mem[index] <= wr_tag;
  end

  // Valid bits clear on reset so an interrupted fill never becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else if (fill_done) valid[index] <= 1'b1;
  end

endmodule

// File: rtl/dcache_controller.sv
// Read-only direct-mapped data cache controller with hit/access statistics.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_address,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   cpu_data,
  output logic                cpu_busy,
  output logic                main_mem_miss,
  output logic [ADDR_W-1:0]   main_mem_address,
  output logic [OFFSET_W-1:0] main_mem_offset,
  input  logic                main_mem_ready,
  input  logic [DATA_W-1:0]   main_mem_data,
  output logic [CNT_W-1:0]    access_count,
  output logic [CNT_W-1:0]    hit_count
);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic                refill;
  logic [OFFSET_W-1:0] fill_cnt;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_word;
  logic                hit;
  logic                word_we;
  logic                fill_done;
  logic [INDEX_W-1:0]  idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign idx = get_index(addr_q);
  assign hit = rd_valid && (rd_tag == get_tag(addr_q));

  dcache_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (idx),
    .rd_offset (get_offset(addr_q)),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_word   (rd_word),
    .word_we   (word_we),
    .wr_offset (fill_cnt),
    .wr_data   (main_mem_data),
    .fill_done (fill_done),
    .wr_tag    (get_tag(addr_q))
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, array write strobes and memory-side outputs from registered state.
  always_comb begin
    state_next       = state;
    word_we          = 1'b0;
    fill_done        = 1'b0;
    cpu_busy         = (state != IDLE);
    main_mem_miss    = 1'b0;
    main_mem_address = '0;
    main_mem_offset  = '0;
    case (state)
      IDLE:    if (cpu_req) state_next = COMPARE;
      COMPARE: state_next = hit ? IDLE : FILL;
      FILL: begin
        main_mem_miss    = 1'b1;
        main_mem_address = block_base(addr_q);
        main_mem_offset  = fill_cnt;
        if (main_mem_ready) begin
          word_we = 1'b1;
          if (fill_cnt == '1) begin
            fill_done  = 1'b1;
            state_next = COMPARE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address latch, fill counter, response register and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      refill       <= 1'b0;
      fill_cnt     <= '0;
      cpu_ready    <= 1'b0;
      cpu_data     <= '0;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q <= cpu_address;
            refill <= 1'b0;
          end
        end
        COMPARE: begin
          // Only the first lookup of a request counts toward the statistics.
          if (!refill) begin
            access_count <= sat_inc(access_count);
            if (hit) hit_count <= sat_inc(hit_count);
          end
          if (hit) begin
            cpu_ready <= 1'b1;
            cpu_data  <= rd_word;
          end else begin
            fill_cnt <= '0;
          end
        end
        FILL: begin
          if (main_mem_ready) begin
            fill_cnt <= fill_cnt + OFFSET_W'(1);
            if (fill_cnt == '1) refill <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: expected responses queued at request time.
module tb_dcache_controller;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [14:0] cpu_address;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic        cpu_busy;
  logic        main_mem_miss;
  logic [14:0] main_mem_address;
  logic [1:0]  main_mem_offset;
  logic        main_mem_ready;
  logic [31:0] main_mem_data;
  logic [15:0] access_count;
  logic [15:0] hit_count;

  dcache_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_req          (cpu_req),
    .cpu_address      (cpu_address),
    .cpu_ready        (cpu_ready),
    .cpu_data         (cpu_data),
    .cpu_busy         (cpu_busy),
    .main_mem_miss    (main_mem_miss),
    .main_mem_address (main_mem_address),
    .main_mem_offset  (main_mem_offset),
    .main_mem_ready   (main_mem_ready),
    .main_mem_data    (main_mem_data),
    .access_count     (access_count),
    .hit_count        (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          miss_cycles = 0;
  int          exp_off = 0;
  int          stall_n = 0;
  int          stall_off = 0;
  int          stall_used = 0;
  int          mark;
  bit          seen_ready = 0;
  logic [14:0] cur_base = '0;

  function automatic logic [31:0] mem_model(input int a);
    return 32'(a - 1023);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: response scoreboard, memory model and fill-beat checks.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    seen_ready = 0;
    if (rst_n && cpu_ready) begin
      seen_ready = 1;
      chk("busy_at_ready", cpu_busy, 0);
      if (sb.size() == 0) chk("spurious_ready", 1, 0);
      else begin
        e = sb.pop_front();
        chk("cpu_data", cpu_data, e.data);
        chk("latency", cyc, e.due);
      end
    end
    if (main_mem_miss) begin
      if (stall_used < stall_n && int'(main_mem_offset) == stall_off) begin
        main_mem_ready = 1'b0;
        stall_used++;
      end else main_mem_ready = 1'b1;
      chk("mm_addr", main_mem_address, cur_base);
      chk("mm_off", main_mem_offset, exp_off);
      chk("busy_fill", cpu_busy, 1);
      miss_cycles++;
      main_mem_data = mem_model(int'(main_mem_address) + int'(main_mem_offset));
      if (main_mem_ready) exp_off++;
    end else begin
      main_mem_ready = 1'b0;
      exp_off = 0;
      stall_used = 0;
    end
  endtask

  task automatic issue(input int a, input bit hit, input int extra, input bit push);
    exp_t e;
    e.data = mem_model(a);
    e.due  = cyc + (hit ? 2 : 7 + extra);
    if (push) sb.push_back(e);
    cur_base    = 15'(a & ~3);
    cpu_req     = 1'b1;
    cpu_address = 15'(a);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cpu_ready, 0);
    chk({tag, "_data"}, cpu_data, 0);
    chk({tag, "_busy"}, cpu_busy, 0);
    chk({tag, "_mmiss"}, main_mem_miss, 0);
    chk({tag, "_maddr"}, main_mem_address, 0);
    chk({tag, "_moff"}, main_mem_offset, 0);
    chk({tag, "_acc"}, access_count, 0);
    chk({tag, "_hits"}, hit_count, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    cpu_req        = 1'b0;
    cpu_address    = '0;
    main_mem_ready = 1'b0;
    main_mem_data  = '0;
    tick();
    tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Cold miss on 1024.
    mark = miss_cycles;
    issue(1024, 0, 0, 1);
    drain();
    chk("s1_miss_cycles", miss_cycles - mark, 4);
    chk("s1_acc", access_count, 1);
    chk("s1_hits", hit_count, 0);

    // Spatial hit in the same block.
    mark = miss_cycles;
    issue(1027, 1, 0, 1);
    drain();
    chk("s2_miss_cycles", miss_cycles - mark, 0);
    chk("s2_hits", hit_count, 1);

    // Conflict on index 0; a request during the fill is dropped.
    issue(2048, 0, 0, 1);
    tick();
    cpu_req     = 1'b1;
    cpu_address = 15'd3000;
    tick();
    cpu_req = 1'b0;
    drain();
    issue(1024, 0, 0, 1);
    drain();
    chk("s3_acc", access_count, 4);
    chk("s3_hits", hit_count, 1);

    // Three stalled beats at offset 1, then a hit on the stalled word.
    stall_n   = 3;
    stall_off = 1;
    issue(3074, 0, 3, 1);
    drain();
    stall_n = 0;
    issue(3073, 1, 0, 1);
    drain();
    chk("s4_acc", access_count, 6);
    chk("s4_hits", hit_count, 2);

    // Reset after two accepted beats.
    issue(4100, 0, 0, 0);
    for (int i = 0; i < 20 && exp_off < 2; i++) tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfill");
    tick();
    rst_n = 1'b1;
    tick();
    mark = miss_cycles;
    issue(4100, 0, 0, 1);
    drain();
    chk("s5_miss_cycles", miss_cycles - mark, 4);
    chk("s5_acc", access_count, 1);
    chk("s5_hits", hit_count, 0);

    // Back-to-back hits: second request in the cpu_ready cycle of the first.
    issue(1024, 0, 0, 1);
    drain();
    issue(1024, 1, 0, 1);
    for (int i = 0; i < 20 && !seen_ready; i++) tick();
    chk("s6_first_ready", seen_ready, 1);
    issue(1025, 1, 0, 1);
    drain();
    chk("s6_acc", access_count, 4);
    chk("s6_hits", hit_count, 2);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, read-only data cache controller between the processor datapath and the main memory model. It looks up 15-bit word addresses in a 1K-word cache of 256 four-word blocks. On a miss it fetches the whole block from main memory one word per accepted beat, then returns the requested word. It also keeps access and hit counters so benches can report hit rate.

## Interface
- `ADDR_W`, 15: word address width (`tag[14:10]`, `index[9:2]`, `offset[1:0]`)
- `DATA_W`, 32: word width
- `INDEX_W`, 8: 256 blocks
- `OFFSET_W`, 2: 4 words per block
- `CNT_W`, 16: statistics counter width
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `cpu_req` input 1: read request, sampled only in IDLE
- `cpu_address` input 15: word address, sampled with `cpu_req`
- `cpu_ready` output 1: one-cycle pulse, `cpu_data` valid
- `cpu_data` output 32: returned word, registered, held until next response
- `cpu_busy` output 1: high whenever state ≠ IDLE
- `main_mem_miss` output 1: block fetch in progress
- `main_mem_address` output 15: block base, `{tag,index,2'b00}`
- `main_mem_offset` output 2: word within block being fetched
- `main_mem_ready` input 1: current fetch beat valid
- `main_mem_data` input 32: fetched word
- `access_count` output 16: number of accepted requests
- `hit_count` output 16: number of first-lookup hits

## Operation
- States: IDLE, COMPARE, FILL.
- IDLE:
  - If `cpu_req`, latch `cpu_address` and clear the `refill` flag, then go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE:
  - Hit means `valid[index] && tag_array[index]==tag`.
  - On a hit, register `cpu_data <= data[index][offset]`, pulse `cpu_ready`, and go to IDLE.
  - On a miss, reset the fill counter to 0 and go to FILL.
  - When `refill==0`, `access_count` increments, and `hit_count` also increments if the lookup hit. Lookups with `refill==1` are never counted.
- FILL:
  - `main_mem_miss=1`, `main_mem_offset` = fill counter, `main_mem_address` = latched block base.
  - On each cycle with `main_mem_ready=1`, write `main_mem_data` into `data[index][counter]` and increment the counter.
  - When `main_mem_ready=0`, hold the counter and write nothing (stall).
  - The write of word 3 also sets `valid[index]=1`, sets `tag_array[index]=tag`, sets `refill=1`, and goes to COMPARE. That lookup is guaranteed to hit.
- Writes from the CPU are not supported.
- A `cpu_req` arriving while `cpu_busy` is dropped. The requester waits for `cpu_ready`.
- Counters saturate at all-ones; they do not wrap.

## Timing
- Reset (async, any state):
  - State IDLE; all 256 valid bits cleared; counters 0.
  - `cpu_ready`, `cpu_data`, `main_mem_miss`, `main_mem_offset`, `main_mem_address` all 0.
  - Data and tag arrays are not reset.
- Reset in mid-FILL aborts the fetch. The partial block is never marked valid.
- Hit latency: request sampled at edge 0, `cpu_ready` high for the cycle after edge 1.
- Miss latency with no stall: `main_mem_miss` high for cycles 2–5 (offsets 0..3), COMPARE in cycle 6, `cpu_ready` high after edge 6. Each stalled beat adds one cycle.
- `cpu_ready` is high while the state is already IDLE. A `cpu_req` in that same cycle is accepted, giving back-to-back throughput of one hit per 2 cycles.
- `main_mem_miss`, `main_mem_offset` and `main_mem_address` are decoded from registered state. They are glitch-free and stable for the whole beat.

## Structure
- Package `dcache_pkg`:
  - width constants `ADDR_W`, `DATA_W`, `INDEX_W`, `OFFSET_W`, `CNT_W`
  - the state enum `{IDLE, COMPARE, FILL}`
  - tag/index/offset field-slicing functions
- One sub-module `dcache_array`:
  - holds data, tag and valid storage
  - combinational read of tag, valid and word
  - synchronous word write, plus synchronous tag/valid write on fill completion
  - async clear of valid
- The controller holds the FSM, address latch, fill counter and statistics counters.

## Test plan
- Memory model holds `mem[a] = a-1023` for a in 1024..9215.
- Scenario 1, cold miss: after reset, read 1024.
  - Required: `main_mem_miss` for 4 cycles, `main_mem_address=1024`, offsets 0,1,2,3.
  - Required: `cpu_ready` with `cpu_data=1` after edge 6; `access_count=1`, `hit_count=0`.
- Scenario 2, spatial hit: read 1027 next → `cpu_ready` after edge 1, `cpu_data=4`, no `main_mem_miss`, `hit_count=1`.
- Scenario 3, conflict: read 2048 (index 0, tag 2) → miss, `cpu_data=1025`; then read 1024 → miss again, `cpu_data=1`; `access_count=4`, `hit_count=1`.
- Scenario 4, stall: hold `main_mem_ready=0` for 3 cycles while offset=1.
  - Required: offset stays 1, nothing is written, `cpu_ready` arrives 3 cycles later with correct data.
  - Required: a later read of the offset-1 word hits with the correct value.
- Scenario 5, reset mid-fill: assert `rst_n=0` after 2 beats.
  - Required: all outputs 0 and counters 0.
  - Required: re-reading the same address misses and does the full 4-beat fetch.
- Scenario 6, back-to-back: assert `cpu_req` for 1025 in the `cpu_ready` cycle of a hit → accepted; response arrives 2 cycles later with `cpu_data=2`.
